// File: rtl/reset_seq_pkg.sv
// reset_seq_pkg: shared types and constants for the reset sequencer.
//   state_t    - sequencer FSM states
//   CAUSE_*    - rst_cause encodings
//   cnt_width  - bits needed to hold a given maximum count (minimum 1)
package reset_seq_pkg;

  typedef enum logic [1:0] {
    ST_ASSERT  = 2'd0,
    ST_RELEASE = 2'd1,
    ST_RUN     = 2'd2,
    ST_PULSE   = 2'd3
  } state_t;

  localparam logic [1:0] CAUSE_POR = 2'b00;
  localparam logic [1:0] CAUSE_EXT = 2'b01;
  localparam logic [1:0] CAUSE_SW  = 2'b10;
  localparam logic [1:0] CAUSE_WDT = 2'b11;

  function automatic int unsigned cnt_width(input int unsigned maxval);
    int unsigned w;
    w = 1;
    while ((64'd1 << w) <= 64'(maxval)) w++;
    return w;
  endfunction

endpackage

// File: rtl/reset_seq_filter.sv
// rst_filter: synchronizes the raw active-low external reset into the clock
// domain and accepts it only after FILTER_CYCLES consecutive low samples.
//   clock, reset  - core clock, async active-high reset
//   ext_rst_n     - raw external reset, active-low, asynchronous
//   trig          - filtered trigger, high while the accepted reset persists
module rst_filter
  import reset_seq_pkg::*;
#(
  parameter int unsigned FILTER_CYCLES = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic ext_rst_n,
  output logic trig
);

  localparam int unsigned FW = cnt_width(FILTER_CYCLES);
  localparam logic [FW-1:0] FMAX  = FW'(FILTER_CYCLES);
  localparam logic [FW-1:0] FLAST = FW'(FILTER_CYCLES - 1);

  logic          s1, s2;
  logic [FW-1:0] lows;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1   <= 1'b1;
      s2   <= 1'b1;
      lows <= '0;
    end else begin
      s1 <= ext_rst_n;
      s2 <= s1;
      if (s2)
        lows <= '0;
      else if (lows != FMAX)
        lows <= lows + 1'b1;
    end
  end

  // Fires in the cycle the current low sample brings the count to
  // FILTER_CYCLES, and stays up while the input remains low.
  assign trig = !s2 && ((lows == FLAST) || (lows == FMAX));

endmodule

// File: rtl/reset_seq.sv
// reset_seq: core-side reset sequencer. Filters the external reset, releases
// per-domain resets in ascending stages, handles software reset requests with
// a one-cycle ack and an outbound pad reset pulse.
//   clock, reset        - core clock, async active-high power-on reset
//   ext_rst_n           - raw external reset, active-low
//   sw_rst_req/ack      - software reset request (level) / one-cycle ack
//   wdt_kick, wdt_load  - watchdog reload strobe / value (RESET_SEQ_WDT_EN only)
//   rst_out             - active-high domain resets
//   pad_rst_out         - outbound reset pulse to the pad level shifter
//   rst_cause           - 00 POR, 01 external, 10 software, 11 watchdog
//   busy                - high whenever the sequencer is not in RUN
// Build option: define RESET_SEQ_WDT_EN to include the watchdog.
module reset_seq
  import reset_seq_pkg::*;
#(
  parameter int unsigned NUM_DOMAINS   = 3,
  parameter int unsigned STAGE_CYCLES  = 16,
  parameter int unsigned FILTER_CYCLES = 4,
  parameter int unsigned PULSE_CYCLES  = 32,
  parameter int unsigned WDT_WIDTH     = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   ext_rst_n,
  input  logic                   sw_rst_req,
  output logic                   sw_rst_ack,
`ifdef RESET_SEQ_WDT_EN
  input  logic                   wdt_kick,
  input  logic [WDT_WIDTH-1:0]   wdt_load,
`endif
  output logic [NUM_DOMAINS-1:0] rst_out,
  output logic                   pad_rst_out,
  output logic [1:0]             rst_cause,
  output logic                   busy
);

  localparam int unsigned CNT_MAX = (STAGE_CYCLES > PULSE_CYCLES) ? STAGE_CYCLES : PULSE_CYCLES;
  localparam int unsigned CW = cnt_width(CNT_MAX - 1);
  localparam int unsigned IW = cnt_width(NUM_DOMAINS - 1);
  localparam logic [CW-1:0] STAGE_LAST = CW'(STAGE_CYCLES - 1);
  localparam logic [CW-1:0] PULSE_LAST = CW'(PULSE_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DOMAINS - 1);

  state_t                 state, state_n;
  logic [CW-1:0]          cnt, cnt_n;
  logic [IW-1:0]          idx, idx_n;
  logic [NUM_DOMAINS-1:0] rst_q, rst_d;
  logic                   pad_q, pad_d;
  logic [1:0]             cause_q, cause_d;
  logic                   ack_q, ack_d;
  logic                   ext_trig;
  logic                   wdt_trig;

  rst_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_filter (
    .clock     (clock),
    .reset     (reset),
    .ext_rst_n (ext_rst_n),
    .trig      (ext_trig)
  );

`ifdef RESET_SEQ_WDT_EN
  logic [WDT_WIDTH-1:0] wdt_cnt, wdt_n;

  always_comb begin
    wdt_n = wdt_cnt;
    if (state_n == ST_RUN && state != ST_RUN)
      wdt_n = wdt_load;
    else if (state == ST_RUN) begin
      if (wdt_kick)
        wdt_n = wdt_load;
      else if (wdt_cnt != '0)
        wdt_n = wdt_cnt - 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) wdt_cnt <= '0;
    else       wdt_cnt <= wdt_n;
  end

  // Trigger on the cycle whose decrement would reach zero, so a load of N
  // expires after exactly N RUN cycles.
  assign wdt_trig = (state == ST_RUN) && (wdt_load != '0) && !wdt_kick &&
                    (wdt_cnt <= WDT_WIDTH'(1));
`else
  assign wdt_trig = 1'b0;
`endif

  always_comb begin
    state_n = state;
    cnt_n   = cnt + 1'b1;
    idx_n   = idx;
    rst_d   = rst_q;
    pad_d   = pad_q;
    cause_d = cause_q;
    ack_d   = 1'b0;
    if (ext_trig) begin
      // External reset overrides every state and restarts the sequence.
      state_n = ST_ASSERT;
      cnt_n   = '0;
      idx_n   = '0;
      rst_d   = '1;
      pad_d   = 1'b0;
      cause_d = CAUSE_EXT;
    end else begin
      case (state)
        ST_ASSERT: begin
          rst_d = '1;
          if (cnt == STAGE_LAST) begin
            state_n = ST_RELEASE;
            cnt_n   = '0;
            idx_n   = '0;
          end
        end
        ST_RELEASE: begin
          if (cnt == STAGE_LAST) begin
            cnt_n      = '0;
            rst_d[idx] = 1'b0;
            if (idx == IDX_LAST)
              state_n = ST_RUN;
            else
              idx_n = idx + 1'b1;
          end
        end
        ST_RUN: begin
          cnt_n = '0;
          if (wdt_trig) begin
            state_n = ST_ASSERT;
            rst_d   = '1;
            cause_d = CAUSE_WDT;
          end else if (sw_rst_req) begin
            state_n = ST_PULSE;
            rst_d   = '1;
            pad_d   = 1'b1;
            cause_d = CAUSE_SW;
            ack_d   = 1'b1;
          end
        end
        ST_PULSE: begin
          rst_d = '1;
          if (cnt == PULSE_LAST) begin
            state_n = ST_ASSERT;
            cnt_n   = '0;
            pad_d   = 1'b0;
          end
        end
        default: begin
          state_n = ST_ASSERT;
          cnt_n   = '0;
          rst_d   = '1;
        end
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= ST_ASSERT;
      cnt     <= '0;
      idx     <= '0;
      rst_q   <= '1;
      pad_q   <= 1'b0;
      cause_q <= CAUSE_POR;
      ack_q   <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      idx     <= idx_n;
      rst_q   <= rst_d;
      pad_q   <= pad_d;
      cause_q <= cause_d;
      ack_q   <= ack_d;
    end
  end

  assign rst_out     = rst_q;
  assign pad_rst_out = pad_q;
  assign rst_cause   = cause_q;
  assign sw_rst_ack  = ack_q;
  assign busy        = (state != ST_RUN);

endmodule

// File: tb/tb_reset_seq.sv
// tb_reset_seq: directed bench for reset_seq with default parameters.
// A vector table drives POR release, software reset, glitch rejection and an
// external re-sequence; hand-written sequences cover collisions, held requests,
// external reset mid-release and asynchronous reset. Watchdog checks are
// included when RESET_SEQ_WDT_EN is defined.
module tb_reset_seq;

  logic       clock;
  logic       reset;
  logic       ext_rst_n;
  logic       sw_rst_req;
  logic       sw_rst_ack;
  logic [2:0] rst_out;
  logic       pad_rst_out;
  logic [1:0] rst_cause;
  logic       busy;
`ifdef RESET_SEQ_WDT_EN
  logic        wdt_kick;
  logic [15:0] wdt_load;
`endif

  int checks = 0;
  int errors = 0;

  reset_seq #(
    .NUM_DOMAINS   (3),
    .STAGE_CYCLES  (16),
    .FILTER_CYCLES (4),
    .PULSE_CYCLES  (32),
    .WDT_WIDTH     (16)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .ext_rst_n   (ext_rst_n),
    .sw_rst_req  (sw_rst_req),
    .sw_rst_ack  (sw_rst_ack),
`ifdef RESET_SEQ_WDT_EN
    .wdt_kick    (wdt_kick),
    .wdt_load    (wdt_load),
`endif
    .rst_out     (rst_out),
    .pad_rst_out (pad_rst_out),
    .rst_cause   (rst_cause),
    .busy        (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    string       name;
    int unsigned cycles;
    logic        ext_n;
    logic        sw;
    logic [2:0]  rst;
    logic        pad;
    logic        ack;
    logic [1:0]  cause;
    logic        busy;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int unsigned n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic chk_all(input string name, input logic [2:0] r, input logic p,
                         input logic a, input logic [1:0] c, input logic b);
    chk({name, "_rst"},   32'(rst_out),     32'(r));
    chk({name, "_pad"},   32'(pad_rst_out), 32'(p));
    chk({name, "_ack"},   32'(sw_rst_ack),  32'(a));
    chk({name, "_cause"}, 32'(rst_cause),   32'(c));
    chk({name, "_busy"},  32'(busy),        32'(b));
  endtask

  // Advance until busy is low, counting acks seen on the way.
  task automatic wait_run(input string name, input int unsigned budget, output int acks);
    bit ok;
    acks = 0;
    ok   = 1'b0;
    for (int unsigned i = 0; i < budget; i++) begin
      if (!busy) begin
        ok = 1'b1;
        break;
      end
      tick(1);
      if (sw_rst_ack) acks++;
    end
    if (!busy) ok = 1'b1;
    chk({name, "_reached_run"}, 32'(ok), 32'd1);
  endtask

  function automatic vec_t mk(input string n, input int unsigned cy, input logic e, input logic s,
                              input logic [2:0] r, input logic p, input logic a,
                              input logic [1:0] c, input logic b);
    vec_t v;
    v.name = n; v.cycles = cy; v.ext_n = e; v.sw = s;
    v.rst = r; v.pad = p; v.ack = a; v.cause = c; v.busy = b;
    return v;
  endfunction

  initial begin
    #500000;
    $display("FAIL global_timeout: actual still running, required finished");
    $fatal(1, "bench timed out");
  end

  initial begin
    int acks;
    reset      = 1'b1;
    ext_rst_n  = 1'b1;
    sw_rst_req = 1'b0;
`ifdef RESET_SEQ_WDT_EN
    wdt_kick = 1'b0;
    wdt_load = '0;
`endif

    // name, cycles, ext_n, sw, rst, pad, ack, cause, busy
    vecs.push_back(mk("por_e31",      31, 1, 0, 3'b111, 0, 0, 2'b00, 1));
    vecs.push_back(mk("por_e32",       1, 1, 0, 3'b110, 0, 0, 2'b00, 1));
    vecs.push_back(mk("por_e47",      15, 1, 0, 3'b110, 0, 0, 2'b00, 1));
    vecs.push_back(mk("por_e48",       1, 1, 0, 3'b100, 0, 0, 2'b00, 1));
    vecs.push_back(mk("por_e63",      15, 1, 0, 3'b100, 0, 0, 2'b00, 1));
    vecs.push_back(mk("por_e64",       1, 1, 0, 3'b000, 0, 0, 2'b00, 0));
    vecs.push_back(mk("run_idle",     10, 1, 0, 3'b000, 0, 0, 2'b00, 0));
    vecs.push_back(mk("sw_accept",     1, 1, 1, 3'b111, 1, 1, 2'b10, 1));
    vecs.push_back(mk("sw_drop",       1, 1, 0, 3'b111, 1, 0, 2'b10, 1));
    vecs.push_back(mk("pulse_e31",    30, 1, 0, 3'b111, 1, 0, 2'b10, 1));
    vecs.push_back(mk("pulse_e32",     1, 1, 0, 3'b111, 0, 0, 2'b10, 1));
    vecs.push_back(mk("sw_reseq_110", 32, 1, 0, 3'b110, 0, 0, 2'b10, 1));
    vecs.push_back(mk("sw_reseq_run", 32, 1, 0, 3'b000, 0, 0, 2'b10, 0));
    vecs.push_back(mk("glitch3",       3, 0, 0, 3'b000, 0, 0, 2'b10, 0));
    vecs.push_back(mk("glitch3_after", 8, 1, 0, 3'b000, 0, 0, 2'b10, 0));
    vecs.push_back(mk("ext4_low",      4, 0, 0, 3'b000, 0, 0, 2'b10, 0));
    vecs.push_back(mk("ext4_e5",       1, 1, 0, 3'b000, 0, 0, 2'b10, 0));
    vecs.push_back(mk("ext4_e6",       1, 1, 0, 3'b111, 0, 0, 2'b01, 1));
    vecs.push_back(mk("ext_reseq_37", 31, 1, 0, 3'b111, 0, 0, 2'b01, 1));
    vecs.push_back(mk("ext_reseq_38",  1, 1, 0, 3'b110, 0, 0, 2'b01, 1));
    vecs.push_back(mk("ext_reseq_54", 16, 1, 0, 3'b100, 0, 0, 2'b01, 1));
    vecs.push_back(mk("ext_reseq_70", 16, 1, 0, 3'b000, 0, 0, 2'b01, 0));

    // Reset state, asserted asynchronously before any clock edge.
    #2;
    chk_all("por_async", 3'b111, 0, 0, 2'b00, 1);
    tick(3);
    chk_all("por_held", 3'b111, 0, 0, 2'b00, 1);
    reset = 1'b0;

    foreach (vecs[i]) begin
      ext_rst_n  = vecs[i].ext_n;
      sw_rst_req = vecs[i].sw;
      tick(vecs[i].cycles);
      chk_all(vecs[i].name, vecs[i].rst, vecs[i].pad, vecs[i].ack, vecs[i].cause, vecs[i].busy);
    end

    // Collision: external trigger and software request on the same edge.
    ext_rst_n = 1'b0;
    tick(5);
    chk("coll_pre_rst", 32'(rst_out), 32'd0);
    sw_rst_req = 1'b1;
    tick(1);
    chk_all("coll_edge", 3'b111, 0, 0, 2'b01, 1);
    sw_rst_req = 1'b0;
    ext_rst_n  = 1'b1;
    tick(1);
    chk_all("coll_next", 3'b111, 0, 0, 2'b01, 1);
    wait_run("coll", 200, acks);
    chk("coll_cause_after", 32'(rst_cause), 32'd1);

    // Held request: acked once in RUN, then ignored outside RUN.
    sw_rst_req = 1'b1;
    tick(1);
    chk_all("held_accept", 3'b111, 1, 1, 2'b10, 1);
    tick(1);
    chk("held_pulse_ack", 32'(sw_rst_ack), 32'd0);
    acks = 0;
    for (int i = 0; i < 62; i++) begin
      tick(1);
      if (sw_rst_ack) acks++;
    end
    tick(1);
    chk("held_no_ack", 32'(acks), 32'd0);
    chk("held_rel_rst", 32'(rst_out), 32'b110);

    // External reset in the middle of RELEASE.
    ext_rst_n = 1'b0;
    tick(5);
    chk("midrel_pre_rst", 32'(rst_out), 32'b110);
    tick(1);
    chk_all("midrel_hit", 3'b111, 0, 0, 2'b01, 1);
    ext_rst_n = 1'b1;
    tick(16);
    chk("midrel_restart_rst", 32'(rst_out), 32'b111);
    wait_run("midrel", 200, acks);
    chk("midrel_no_ack", 32'(acks), 32'd0);
    chk_all("midrel_run", 3'b000, 0, 0, 2'b01, 0);
    tick(1);
    chk_all("held_in_run", 3'b111, 1, 1, 2'b10, 1);
    sw_rst_req = 1'b0;
    tick(1);
    chk("held_ack_drop", 32'(sw_rst_ack), 32'd0);
    wait_run("held", 200, acks);

    // Asynchronous reset during a pad pulse clears everything immediately.
    sw_rst_req = 1'b1;
    tick(1);
    chk("async_pre_pad", 32'(pad_rst_out), 32'd1);
    sw_rst_req = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk_all("async_reset", 3'b111, 0, 0, 2'b00, 1);
    tick(2);

`ifdef RESET_SEQ_WDT_EN
    wdt_load = 16'd100;
    reset = 1'b0;
    wait_run("wdt", 200, acks);
    tick(99);
    chk_all("wdt_99", 3'b000, 0, 0, 2'b00, 0);
    tick(1);
    chk_all("wdt_fire", 3'b111, 0, 0, 2'b11, 1);
    wait_run("wdt_kick", 200, acks);
    for (int k = 0; k < 6; k++) begin
      tick(49);
      wdt_kick = 1'b1;
      tick(1);
      wdt_kick = 1'b0;
    end
    chk_all("wdt_kicked", 3'b000, 0, 0, 2'b11, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
